// File: rtl/dac_spi_master.sv
// rtl/dac_spi_master.sv - SPI master serialising DAC codes to NCH chip-selected DACs
// Optional LDAC strobe after each frame is enabled by defining DAC_SPI_LDAC_EN.
module dac_spi_master #(
    parameter int DATA_W  = 16,
    parameter int NCH     = 2,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    output logic [NCH-1:0]    cs_n,
    output logic              sclk,
    output logic              sdi,
    output logic              done,
    output logic              err
`ifdef DAC_SPI_LDAC_EN
    ,
    output logic              ldac_n
`endif
);
`ifdef DAC_SPI_LDAC_EN
    // The gap must be long enough to fit the LDAC strobe after cs_n rises.
    localparam int GAP_CYC = (CS_GAP > CLK_DIV + 2) ? CS_GAP : CLK_DIV + 2;
`else
    localparam int GAP_CYC = CS_GAP;
`endif
    localparam int CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HALF_W  = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [HALF_W-1:0]   r_half;
    logic [DATA_W-1:0]   r_shift;
    logic [CH_W-1:0]     r_ch;
    logic                r_armed;
    logic                r_err;
    logic                w_accept;
    logic                w_ch_bad;
    logic                w_tick;
    logic                w_last_half;
    logic                w_gap_end;
    logic                w_frame;

    assign w_accept    = in_valid && in_ready;
    assign w_ch_bad    = (32'(in_ch) >= 32'(NCH));
    assign w_tick      = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_gap_end   = (r_cnt == CNT_W'(GAP_CYC - 1));
    assign w_last_half = (r_half == HALF_W'(2 * DATA_W - 1));
    assign w_frame     = (r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_ch_bad) w_next = S_SETUP;
            S_SETUP: if (w_tick) w_next = S_SHIFT;
            S_SHIFT: if (w_tick && w_last_half) w_next = S_HOLD;
            S_HOLD:  if (w_tick) w_next = S_GAP;
            S_GAP:   if (w_gap_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Even half-periods have sclk low; data advances on entry to each low half after the first.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt   <= '0;
            r_half  <= '0;
            r_shift <= '0;
            r_ch    <= '0;
            r_armed <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_err   <= w_accept && w_ch_bad;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept && !w_ch_bad) begin
                        r_shift <= in_data;
                        r_ch    <= in_ch;
                        r_half  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (!w_last_half) begin
                            r_half <= r_half + 1'b1;
                            if (r_half[0]) r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == S_IDLE) && r_armed;
        cs_n     = '1;
        for (int i = 0; i < NCH; i++) begin
            if (w_frame && (r_ch == CH_W'(i))) cs_n[i] = 1'b0;
        end
        sclk = (r_state == S_SHIFT) ? r_half[0] : 1'b1;
        sdi  = r_shift[DATA_W-1];
        done = (r_state == S_GAP) && (r_cnt == '0);
        err  = r_err;
`ifdef DAC_SPI_LDAC_EN
        ldac_n = !((r_state == S_GAP) && (r_cnt != '0) && (r_cnt <= CNT_W'(CLK_DIV)));
`endif
    end

endmodule

// File: tb/tb_dac_spi_master.sv
// tb/tb_dac_spi_master.sv - randomized self-checking bench for dac_spi_master
// Two instances: defaults, and DATA_W=24/NCH=3/CLK_DIV=1/CS_GAP=3.
module tb_dac_spi_master;
    localparam int DIV0 = 2;
    localparam int GAP0 = 4;
    localparam int DIV1 = 1;
    localparam int GAP1 = 3;

    typedef struct packed {
        int          len;
        logic [31:0] bits;
        int          nbits;
        int          ch;
        logic        done_ok;
    } frame_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        v0, rdy0, sck0, sdi0, dn0, er0;
    logic [15:0] d0;
    logic [0:0]  c0;
    logic [1:0]  cs0;
    logic        v1, rdy1, sck1, sdi1, dn1, er1;
    logic [23:0] d1;
    logic [1:0]  c1;
    logic [2:0]  cs1;
`ifdef DAC_SPI_LDAC_EN
    logic        ldac0, ldac1;
    int          ldac_bad = 0;
    int          ldac_low = 0;
`endif

    int     nvec = 0;
    int     nerr = 0;
    int     cyc = 0;
    frame_t m_cur[2];
    bit     m_act[2];
    bit     m_ended[2];
    logic   m_sck[2];
    logic   m_sdi[2];
    int     m_since[2] = '{99, 99};
    int     m_viol[2] = '{0, 0};
    int     m_done[2] = '{0, 0};
    frame_t fq0[$];
    frame_t fq1[$];
    int     gq0[$];
    int     acc0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_master #(.DATA_W(16), .NCH(2), .CLK_DIV(DIV0), .CS_GAP(GAP0)) dut0 (
        .clk(clk), .nrst(nrst), .in_valid(v0), .in_ready(rdy0), .in_data(d0), .in_ch(c0),
        .cs_n(cs0), .sclk(sck0), .sdi(sdi0), .done(dn0), .err(er0)
`ifdef DAC_SPI_LDAC_EN
        , .ldac_n(ldac0)
`endif
    );

    dac_spi_master #(.DATA_W(24), .NCH(3), .CLK_DIV(DIV1), .CS_GAP(GAP1)) dut1 (
        .clk(clk), .nrst(nrst), .in_valid(v1), .in_ready(rdy1), .in_data(d1), .in_ch(c1),
        .cs_n(cs1), .sclk(sck1), .sdi(sdi1), .done(dn1), .err(er1)
`ifdef DAC_SPI_LDAC_EN
        , .ldac_n(ldac1)
`endif
    );

    // Reference: a frame is the cs_n-low window; bits are sdi at sclk rising edges.
    function automatic frame_t model(input logic [31:0] data, input int ch, input int dw, input int div);
        frame_t f;
        f.len     = div + 2 * dw * div + div;
        f.bits    = data;
        f.nbits   = dw;
        f.ch      = ch;
        f.done_ok = 1'b1;
        return f;
    endfunction

    task automatic mon_step(input int id, input logic [7:0] csn, input logic sck, input logic sd,
                            input logic dn, input logic rst_n);
        bit act;
        int nlow;
        int lowi;
        if (!rst_n) begin
            m_act[id] = 0; m_ended[id] = 0; m_since[id] = 99; m_sck[id] = 1'b1; m_sdi[id] = sd;
            return;
        end
        act = (csn != 8'hFF);
        nlow = 0; lowi = 0;
        for (int i = 0; i < 8; i++) if (!csn[i]) begin nlow++; lowi = i; end
        if (nlow > 1) m_viol[id]++;
        if (dn) m_done[id]++;
        if (act) begin
            if (!m_act[id]) begin
                m_cur[id] = '0;
                m_cur[id].ch = lowi;
                if (m_ended[id] && id == 0) gq0.push_back(m_since[id]);
            end else if (sd !== m_sdi[id] && !(m_sck[id] === 1'b1 && sck === 1'b0)) begin
                m_viol[id]++;
            end
            m_cur[id].len++;
            if (m_sck[id] === 1'b0 && sck === 1'b1) begin
                m_cur[id].bits = {m_cur[id].bits[30:0], sd};
                m_cur[id].nbits++;
            end
            m_since[id] = 0;
        end else begin
            if (m_act[id]) begin
                m_cur[id].done_ok = dn;
                if (id == 0) fq0.push_back(m_cur[id]); else fq1.push_back(m_cur[id]);
                m_ended[id] = 1;
            end else if (dn) begin
                m_viol[id]++;
            end
            if (m_since[id] < 1000) m_since[id]++;
        end
        m_act[id] = act;
        m_sck[id] = sck;
        m_sdi[id] = sd;
    endtask

    always @(negedge clk) begin
        mon_step(0, {6'h3F, cs0}, sck0, sdi0, dn0, nrst);
        mon_step(1, {5'h1F, cs1}, sck1, sdi1, dn1, nrst);
`ifdef DAC_SPI_LDAC_EN
        if (nrst) begin
            if (ldac0 !== !(m_since[0] >= 2 && m_since[0] <= DIV0 + 1)) ldac_bad++;
            if (ldac1 !== !(m_since[1] >= 2 && m_since[1] <= DIV1 + 1)) ldac_bad++;
            if (!ldac0) ldac_low++;
        end
`endif
    end

    task automatic drive0(input logic [15:0] d, input logic [0:0] ch, input bit keep);
        int n = 0;
        @(negedge clk);
        v0 = 1'b1; d0 = d; c0 = ch;
        while (!rdy0 && n < 500) begin @(negedge clk); n++; end
        nvec++;
        if (!rdy0) begin nerr++; $display("FAIL drive0 timeout: in_ready=%b want 1", rdy0); end
        @(posedge clk); #1;
        acc0.push_back(cyc);
        d0 = 16'($urandom); c0 = 1'($urandom);
        if (!keep) v0 = 1'b0;
    endtask

    task automatic drive1(input logic [23:0] d, input logic [1:0] ch);
        int n = 0;
        @(negedge clk);
        v1 = 1'b1; d1 = d; c1 = ch;
        while (!rdy1 && n < 500) begin @(negedge clk); n++; end
        nvec++;
        if (!rdy1) begin nerr++; $display("FAIL drive1 timeout: in_ready=%b want 1", rdy1); end
        @(posedge clk); #1;
        v1 = 1'b0; d1 = 24'($urandom); c1 = 2'($urandom_range(2));
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({cs0, sck0, sdi0, dn0, er0, rdy0} !== 7'b11_1_0_0_0_0) begin
            nerr++; $display("FAIL reset0: cs/sclk/sdi/done/err/rdy=%b want 1110000", {cs0, sck0, sdi0, dn0, er0, rdy0});
        end
        nvec++;
        if ({cs1, sck1, sdi1, dn1, er1, rdy1} !== 8'b111_1_0_0_0_0) begin
            nerr++; $display("FAIL reset1: cs/sclk/sdi/done/err/rdy=%b want 11110000", {cs1, sck1, sdi1, dn1, er1, rdy1});
        end
        nrst = 1'b1;
        #1;
        nvec++;
        if (rdy0 !== 1'b0) begin nerr++; $display("FAIL ready_early: in_ready=%b want 0", rdy0); end
        @(posedge clk); #1;
        nvec++;
        if ({rdy0, rdy1} !== 2'b11) begin nerr++; $display("FAIL ready_rise: in_ready=%b want 11", {rdy0, rdy1}); end
    endtask

    task automatic test_single();
        frame_t got, exp;
        int n = 0;
        int dbefore = m_done[0];
        fq0.delete();
        drive0(16'hA5C3, 1'b0, 1'b0);
        while (fq0.size() < 1 && n < 500) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        nvec++;
        if (fq0.size() != 1) begin
            nerr++; $display("FAIL single_count: frames=%0d want 1", fq0.size());
        end else begin
            got = fq0.pop_front();
            exp = model(32'hA5C3, 0, 16, DIV0);
            nvec++;
            if (got !== exp) begin
                nerr++; $display("FAIL single_frame: len=%0d bits=%h n=%0d ch=%0d done=%b want len=%0d bits=%h n=%0d ch=%0d done=1",
                    got.len, got.bits, got.nbits, got.ch, got.done_ok, exp.len, exp.bits, exp.nbits, exp.ch);
            end
        end
        nvec++;
        if (m_done[0] - dbefore != 1) begin nerr++; $display("FAIL single_done: pulses=%0d want 1", m_done[0] - dbefore); end
    endtask

    task automatic test_random();
        frame_t expq[$];
        frame_t got, exp;
        int n = 0;
        fq0.delete();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] d = 16'($urandom);
            logic [0:0]  c = 1'($urandom);
            expq.push_back(model({16'h0, d}, int'(c), 16, DIV0));
            drive0(d, c, 1'b0);
        end
        while (fq0.size() < 8 && n < 2000) begin @(negedge clk); n++; end
        nvec++;
        if (fq0.size() != 8) begin nerr++; $display("FAIL random_count: frames=%0d want 8", fq0.size()); end
        while (fq0.size() > 0 && expq.size() > 0) begin
            got = fq0.pop_front(); exp = expq.pop_front();
            nvec++;
            if (got !== exp) begin
                nerr++; $display("FAIL random_frame: len=%0d bits=%h ch=%0d done=%b want len=%0d bits=%h ch=%0d",
                    got.len, got.bits, got.ch, got.done_ok, exp.len, exp.bits, exp.ch);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] dl[5];
        frame_t got, exp;
        int n = 0;
        dl[0] = 16'h0001; dl[1] = 16'hFFFF;
        for (int i = 2; i < 5; i++) dl[i] = 16'($urandom);
        fq0.delete(); gq0.delete(); acc0.delete();
        for (int i = 0; i < 5; i++) drive0(dl[i], 1'b1, (i < 4));
        while (fq0.size() < 5 && n < 2000) begin @(negedge clk); n++; end
        nvec++;
        if (fq0.size() != 5) begin nerr++; $display("FAIL b2b_count: frames=%0d want 5", fq0.size()); end
        for (int i = 0; i < 5 && fq0.size() > 0; i++) begin
            got = fq0.pop_front(); exp = model({16'h0, dl[i]}, 1, 16, DIV0);
            nvec++;
            if (got !== exp) begin
                nerr++; $display("FAIL b2b_frame%0d: len=%0d bits=%h ch=%0d want len=%0d bits=%h ch=%0d",
                    i, got.len, got.bits, got.ch, exp.len, exp.bits, exp.ch);
            end
        end
        foreach (gq0[i]) begin
            nvec++;
            if (gq0[i] < GAP0) begin nerr++; $display("FAIL b2b_gap%0d: high=%0d want >=%0d", i, gq0[i], GAP0); end
        end
        for (int i = 1; i < acc0.size(); i++) begin
            nvec++;
            if (acc0[i] - acc0[i-1] < 73) begin
                nerr++; $display("FAIL b2b_interval%0d: cycles=%0d want >=73", i, acc0[i] - acc0[i-1]);
            end
        end
    endtask

    task automatic test_bad_channel();
        int nbefore = fq1.size();
        @(negedge clk);
        v1 = 1'b1; c1 = 2'd3; d1 = 24'($urandom);
        @(posedge clk); #1;
        nvec++;
        if ({er1, cs1, rdy1} !== 5'b1_111_1) begin
            nerr++; $display("FAIL badch_pulse: err/cs/rdy=%b want 11111", {er1, cs1, rdy1});
        end
        v1 = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if ({er1, cs1, rdy1} !== 5'b0_111_1) begin
            nerr++; $display("FAIL badch_after: err/cs/rdy=%b want 01111", {er1, cs1, rdy1});
        end
        repeat (10) @(negedge clk);
        nvec++;
        if (fq1.size() != nbefore) begin nerr++; $display("FAIL badch_frame: frames=%0d want %0d", fq1.size(), nbefore); end
    endtask

    task automatic test_wide();
        logic [23:0] dl[5];
        logic [1:0]  cl[5];
        frame_t got, exp;
        int n = 0;
        dl[0] = 24'h800001; cl[0] = 2'd2;
        for (int i = 1; i < 5; i++) begin dl[i] = 24'($urandom); cl[i] = 2'($urandom_range(2)); end
        fq1.delete();
        for (int i = 0; i < 5; i++) drive1(dl[i], cl[i]);
        while (fq1.size() < 5 && n < 2000) begin @(negedge clk); n++; end
        nvec++;
        if (fq1.size() != 5) begin nerr++; $display("FAIL wide_count: frames=%0d want 5", fq1.size()); end
        for (int i = 0; i < 5 && fq1.size() > 0; i++) begin
            got = fq1.pop_front(); exp = model({8'h0, dl[i]}, int'(cl[i]), 24, DIV1);
            nvec++;
            if (got !== exp) begin
                nerr++; $display("FAIL wide_frame%0d: len=%0d bits=%h ch=%0d done=%b want len=%0d bits=%h ch=%0d",
                    i, got.len, got.bits, got.ch, got.done_ok, exp.len, exp.bits, exp.ch);
            end
        end
    endtask

    task automatic test_mid_reset();
        frame_t got, exp;
        logic [15:0] d;
        int n = 0;
        int dbefore, qbefore;
        fq0.delete();
        drive0(16'($urandom), 1'b0, 1'b0);
        while (!(m_act[0] && m_cur[0].nbits == 7) && n < 500) begin @(negedge clk); n++; end
        nvec++;
        if (n >= 500) begin nerr++; $display("FAIL midrst_wait: bit7 not reached, nbits=%0d want 7", m_cur[0].nbits); end
        dbefore = m_done[0]; qbefore = fq0.size();
        @(posedge clk); #2;
        nrst = 1'b0;
        #1;
        nvec++;
        if ({cs0, sck0, sdi0, dn0} !== 5'b11_1_0_0) begin
            nerr++; $display("FAIL midrst_outputs: cs/sclk/sdi/done=%b want 11100", {cs0, sck0, sdi0, dn0});
        end
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(negedge clk);
        nvec++;
        if ((m_done[0] != dbefore) || (fq0.size() != qbefore)) begin
            nerr++; $display("FAIL midrst_abort: done=%0d frames=%0d want done=%0d frames=%0d",
                m_done[0], fq0.size(), dbefore, qbefore);
        end
        d = 16'($urandom);
        drive0(d, 1'b1, 1'b0);
        n = 0;
        while (fq0.size() < qbefore + 1 && n < 500) begin @(negedge clk); n++; end
        nvec++;
        if (fq0.size() != qbefore + 1) begin
            nerr++; $display("FAIL midrst_new_count: frames=%0d want %0d", fq0.size(), qbefore + 1);
        end else begin
            got = fq0.pop_back(); exp = model({16'h0, d}, 1, 16, DIV0);
            nvec++;
            if (got !== exp) begin
                nerr++; $display("FAIL midrst_new_frame: len=%0d bits=%h ch=%0d want len=%0d bits=%h ch=%0d",
                    got.len, got.bits, got.ch, exp.len, exp.bits, exp.ch);
            end
        end
    endtask

    task automatic test_invariants();
        nvec++;
        if (m_viol[0] != 0 || m_viol[1] != 0) begin
            nerr++; $display("FAIL invariants: violations=%0d/%0d want 0/0", m_viol[0], m_viol[1]);
        end
`ifdef DAC_SPI_LDAC_EN
        nvec++;
        if (ldac_bad != 0 || ldac_low == 0) begin
            nerr++; $display("FAIL ldac: bad=%0d low_cycles=%0d want bad=0 low>0", ldac_bad, ldac_low);
        end
`endif
    endtask

    initial begin
        v0 = 1'b0; d0 = '0; c0 = '0;
        v1 = 1'b0; d1 = '0; c1 = '0;
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_bad_channel();
        test_wide();
        test_mid_reset();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
